// File: rtl/hazard_scoreboard.sv
// In-order issue interlock: one down-counter per architectural register tracks pending writes.
// Optional macro FORWARDING_EN: loads hold one bubble, ALU writers never stall.
module hazard_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int WB_LATENCY  = 3,
    parameter int CNT_W       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic [REG_ADDR_W-1:0]  rs,
    input  logic [REG_ADDR_W-1:0]  rt,
    input  logic                   uses_rs,
    input  logic                   uses_rt,
    input  logic [REG_ADDR_W-1:0]  rd,
    input  logic                   writes_reg,
    input  logic                   is_load,
    input  logic                   flush,
    output logic                   stall,
    output logic                   bubble,
    output logic                   issue_fire,
    output logic [NUM_REGS-1:0]    pending_mask,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic [CNT_W-1:0]       cnt_q [NUM_REGS];
    logic [CNT_W-1:0]       cnt_d [NUM_REGS];
    logic [STALL_CNT_W-1:0] stall_cycles_q;
    logic [STALL_CNT_W-1:0] stall_cycles_d;
    logic                   hazard_rs_s;
    logic                   hazard_rt_s;
    logic                   stall_s;
    logic                   fire_s;
    logic [CNT_W-1:0]       load_val_s;

`ifdef FORWARDING_EN
    // Forwarding covers ALU results; only a load's data is late by one cycle.
    always_comb begin
        if (is_load) begin
            load_val_s = CNT_W'(1);
        end else begin
            load_val_s = {CNT_W{1'b0}};
        end
    end
`else
    logic unused_is_load_s;
    assign unused_is_load_s = is_load;
    assign load_val_s       = CNT_W'(WB_LATENCY);
`endif

    // Hazard detection reads pre-update counters, so an instruction never waits on itself.
    always_comb begin
        hazard_rs_s = uses_rs && (rs != {REG_ADDR_W{1'b0}}) && (cnt_q[rs] != {CNT_W{1'b0}});
        hazard_rt_s = uses_rt && (rt != {REG_ADDR_W{1'b0}}) && (cnt_q[rt] != {CNT_W{1'b0}});
        stall_s     = issue_valid && (hazard_rs_s || hazard_rt_s) && !flush;
        fire_s      = issue_valid && !stall_s && !flush;
    end

    // Next counter values: flush clears, a firing writer reloads, otherwise count down.
    always_comb begin
        cnt_d[0] = {CNT_W{1'b0}};
        for (int r = 1; r < NUM_REGS; r++) begin
            if (flush) begin
                cnt_d[r] = {CNT_W{1'b0}};
            end else if (fire_s && writes_reg && (rd == REG_ADDR_W'(r))) begin
                cnt_d[r] = load_val_s;
            end else if (cnt_q[r] != {CNT_W{1'b0}}) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
    end

    // Saturating stall statistics.
    always_comb begin
        if (stall_s && (stall_cycles_q != {STALL_CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // Counter and statistics state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= {CNT_W{1'b0}};
            end
            stall_cycles_q <= {STALL_CNT_W{1'b0}};
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Pending view of the counters.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_mask[r] = (cnt_q[r] != {CNT_W{1'b0}});
        end
    end

    assign stall        = stall_s;
    assign bubble       = stall_s;
    assign issue_fire   = fire_s;
    assign stall_cycles = stall_cycles_q;

endmodule
